// File: rtl/spk_in.sv
// spk_in: node-side receive endpoint of the credit-based NoC flit link.
// Incoming flits are buffered in a 2^B-entry FIFO. One credit goes back
// upstream for every flit that is dequeued. Each flit is then routed by its
// type field: SPIKE flits go to the dendrite, and DATA/DATA_END/WRITE/READ
// flits go to the config controller.
// Optional feature: define SPK_IN_STAT_EN to build the spike and drop
// statistics counters. When it is undefined, both counter ports read 0.
module spk_in #(
    parameter int B   = 4,
    parameter int FW  = 59,
    parameter int FTW = 3,
    parameter int SW  = 24
) (
    input  logic           clk_spk_in,
    input  logic           rst,
    input  logic           flit_in_wr,
    input  logic [FW-1:0]  flit_in,
    output logic           credit_out,
    output logic           spk_in_valid,
    output logic [SW-1:0]  spk_in_neuid,
    input  logic           spk_in_ready,
    output logic           config_in_valid,
    output logic [FTW-1:0] config_in_type,
    output logic [FW-1:0]  config_in_data,
    output logic           config_in_last,
    input  logic           config_in_ready,
    output logic           spk_in_overflow,
    output logic [15:0]    spk_in_spk_cnt,
    output logic [15:0]    spk_in_drop_cnt
);

    localparam int         DEPTH    = 1 << B;
    localparam logic [B:0] FULL_CNT = (B+1)'(DEPTH);

    localparam logic [FTW-1:0] T_SPIKE    = FTW'(3'b000);
    localparam logic [FTW-1:0] T_DATA     = FTW'(3'b001);
    localparam logic [FTW-1:0] T_DATA_END = FTW'(3'b010);
    localparam logic [FTW-1:0] T_WRITE    = FTW'(3'b110);
    localparam logic [FTW-1:0] T_READ     = FTW'(3'b111);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SPK,
        S_CFG
    } state_t;

    // Any type outside the five defined codes is discarded after the pop.
    function automatic logic type_known(input logic [FTW-1:0] t);
        case (t)
            T_SPIKE, T_DATA, T_DATA_END, T_WRITE, T_READ: type_known = 1'b1;
            default:                                      type_known = 1'b0;
        endcase
    endfunction

    // ---------------------------------------------------------------- FIFO
    logic [FW-1:0] mem [DEPTH];
    logic [B-1:0]  wptr_q, wptr_d;
    logic [B-1:0]  rptr_q, rptr_d;
    logic [B:0]    cnt_q, cnt_d;
    logic [FW-1:0] rdata_q;
    logic          credit_q;
    logic          ovf_q;

    state_t        state_q;
    logic [FW-1:0] flit_q;
    logic          spk_vld_q;
    logic          cfg_vld_q;
    logic          last_q;

    logic          fifo_empty;
    logic          fifo_full;
    logic          pop;
    logic          push;
    logic          ovf_drop;
    logic [FTW-1:0] rd_type;

    // FIFO control. A push into a full FIFO is accepted only when the same
    // cycle pops, so stored data is never overwritten.
    always_comb begin
        fifo_empty = (cnt_q == '0);
        fifo_full  = (cnt_q == FULL_CNT);
        pop        = (state_q == S_IDLE) && !fifo_empty;
        push       = flit_in_wr && (!fifo_full || pop);
        ovf_drop   = flit_in_wr && fifo_full && !pop;
        wptr_d     = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d     = pop  ? rptr_q + 1'b1 : rptr_q;
        cnt_d      = cnt_q + (B+1)'(push) - (B+1)'(pop);
        rd_type    = rdata_q[FW-1 -: FTW];
    end

    // Storage array. It has no reset: the pointers define which entries are live.
    always_ff @(posedge clk_spk_in) begin
        if (push) begin
            mem[wptr_q] <= flit_in;
        end
    end

    // Pointers, registered read port, credit pulse and sticky overflow flag.
    always_ff @(posedge clk_spk_in or posedge rst) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            credit_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            credit_q <= pop;
            ovf_q    <= ovf_q | ovf_drop;
            if (pop) begin
                rdata_q <= mem[rptr_q];
            end
        end
    end

    // ----------------------------------------------------------------- FSM
    // Dequeue, decode and present one flit at a time. Valid flags and the
    // presented flit are held in registers, so the data cannot change while
    // valid is high.
    always_ff @(posedge clk_spk_in or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            flit_q    <= '0;
            spk_vld_q <= 1'b0;
            cfg_vld_q <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    flit_q <= rdata_q;
                    last_q <= (rd_type == T_DATA_END);
                    if (rd_type == T_SPIKE) begin
                        spk_vld_q <= 1'b1;
                        state_q   <= S_SPK;
                    end else if (type_known(rd_type)) begin
                        cfg_vld_q <= 1'b1;
                        state_q   <= S_CFG;
                    end else begin
                        state_q   <= S_IDLE;
                    end
                end
                S_SPK: begin
                    if (spk_in_ready) begin
                        spk_vld_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                S_CFG: begin
                    if (config_in_ready) begin
                        cfg_vld_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                default: begin
                    spk_vld_q <= 1'b0;
                    cfg_vld_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign credit_out      = credit_q;
    assign spk_in_overflow = ovf_q;
    assign spk_in_valid    = spk_vld_q;
    assign spk_in_neuid    = flit_q[SW-1:0];
    assign config_in_valid = cfg_vld_q;
    assign config_in_type  = flit_q[FW-1 -: FTW];
    assign config_in_data  = flit_q;
    assign config_in_last  = last_q;

    // ---------------------------------------------------------- statistics
`ifdef SPK_IN_STAT_EN
    logic [15:0] spk_cnt_q;
    logic [15:0] drop_cnt_q;
    logic        spk_acc;
    logic        unk_drop;

    // An overflow drop and an unknown-type discard can occur in the same
    // cycle. In that case, both are counted.
    always_comb begin
        spk_acc  = (state_q == S_SPK) && spk_in_ready;
        unk_drop = (state_q == S_LOAD) && !type_known(rd_type);
    end

    // Wrapping 16-bit counters.
    always_ff @(posedge clk_spk_in or posedge rst) begin
        if (rst) begin
            spk_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            spk_cnt_q  <= spk_cnt_q + 16'(spk_acc);
            drop_cnt_q <= drop_cnt_q + 16'(ovf_drop) + 16'(unk_drop);
        end
    end

    assign spk_in_spk_cnt  = spk_cnt_q;
    assign spk_in_drop_cnt = drop_cnt_q;
`else
    assign spk_in_spk_cnt  = 16'h0000;
    assign spk_in_drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_spk_in.sv
// tb_spk_in: self-checking bench for spk_in. It uses a table of single-flit
// vectors, hand-written multi-cycle sequences (timing, config hold, overflow,
// mid-operation reset), and a random phase checked against an in-order
// scoreboard. Counter expectations follow SPK_IN_STAT_EN.
module tb_spk_in;
    localparam int B   = 4;
    localparam int FW  = 59;
    localparam int FTW = 3;
    localparam int SW  = 24;
`ifdef SPK_IN_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic           clk_spk_in = 1'b0;
    logic           rst = 1'b1;
    logic           flit_in_wr = 1'b0;
    logic [FW-1:0]  flit_in = '0;
    logic           credit_out;
    logic           spk_in_valid;
    logic [SW-1:0]  spk_in_neuid;
    logic           spk_in_ready = 1'b0;
    logic           config_in_valid;
    logic [FTW-1:0] config_in_type;
    logic [FW-1:0]  config_in_data;
    logic           config_in_last;
    logic           config_in_ready = 1'b0;
    logic           spk_in_overflow;
    logic [15:0]    spk_in_spk_cnt;
    logic [15:0]    spk_in_drop_cnt;

    spk_in #(.B(B), .FW(FW), .FTW(FTW), .SW(SW)) dut (
        .clk_spk_in      (clk_spk_in),
        .rst             (rst),
        .flit_in_wr      (flit_in_wr),
        .flit_in         (flit_in),
        .credit_out      (credit_out),
        .spk_in_valid    (spk_in_valid),
        .spk_in_neuid    (spk_in_neuid),
        .spk_in_ready    (spk_in_ready),
        .config_in_valid (config_in_valid),
        .config_in_type  (config_in_type),
        .config_in_data  (config_in_data),
        .config_in_last  (config_in_last),
        .config_in_ready (config_in_ready),
        .spk_in_overflow (spk_in_overflow),
        .spk_in_spk_cnt  (spk_in_spk_cnt),
        .spk_in_drop_cnt (spk_in_drop_cnt)
    );

    always #5 clk_spk_in = ~clk_spk_in;

    int total = 0;
    int bad   = 0;
    int credit_seen = 0;

    // Running count of credit pulses, sampled mid-cycle.
    always @(negedge clk_spk_in) if (credit_out) credit_seen++;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  t;
        logic [55:0] pl;
        int          route;   // 0 discarded, 1 dendrite, 2 config
        logic [23:0] neuid;
        logic        last;
    } vec_t;
    vec_t tbl [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_spk_in);
        #1;
    endtask

    function automatic logic [FW-1:0] mk(input logic [2:0] t, input logic [55:0] pl);
        return {t, pl};
    endfunction

    function automatic bit known(input logic [2:0] t);
        return (t == 3'b000) || (t == 3'b001) || (t == 3'b010) || (t == 3'b110) || (t == 3'b111);
    endfunction

    function automatic logic [15:0] cexp(input int n);
        return STAT ? 16'(n) : 16'h0000;
    endfunction

    task automatic send(input logic [FW-1:0] f);
        flit_in    = f;
        flit_in_wr = 1'b1;
        tick();
        flit_in_wr = 1'b0;
    endtask

    task automatic wait_valid(input bit cfg, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (cfg ? config_in_valid : spk_in_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic check_rst_vals(input string p);
        check({p, " credit"},   64'(credit_out), 64'(0));
        check({p, " spk_vld"},  64'(spk_in_valid), 64'(0));
        check({p, " cfg_vld"},  64'(config_in_valid), 64'(0));
        check({p, " last"},     64'(config_in_last), 64'(0));
        check({p, " neuid"},    64'(spk_in_neuid), 64'(0));
        check({p, " type"},     64'(config_in_type), 64'(0));
        check({p, " data"},     64'(config_in_data), 64'(0));
        check({p, " overflow"}, 64'(spk_in_overflow), 64'(0));
        check({p, " spk_cnt"},  64'(spk_in_spk_cnt), 64'(0));
        check({p, " drop_cnt"}, 64'(spk_in_drop_cnt), 64'(0));
    endtask

    initial begin
        int exp_spk, exp_drop, c0, ups, route;
        bit ok, seen, drain;
        bit prev_sv, prev_sr, prev_cv, prev_cr;
        logic [SW-1:0] prev_id, got_id;
        logic [FW-1:0] prev_data, got_data, f;
        logic [FW-1:0] cf [3];
        logic got_last;
        logic [2:0] t;
        logic [FW-1:0] q [$];

        tbl[0] = '{3'b000, 56'h00_0000_0012_3456, 1, 24'h123456, 1'b0};
        tbl[1] = '{3'b000, 56'hA5_5A00_00FF_FFFF, 1, 24'hFFFFFF, 1'b0};
        tbl[2] = '{3'b001, 56'h11_2233_4455_6677, 2, 24'h0, 1'b0};
        tbl[3] = '{3'b010, 56'hFF_FFFF_FFFF_FFFF, 2, 24'h0, 1'b1};
        tbl[4] = '{3'b110, 56'h00_0000_0000_0001, 2, 24'h0, 1'b0};
        tbl[5] = '{3'b111, 56'h80_0000_0000_0000, 2, 24'h0, 1'b0};
        tbl[6] = '{3'b011, 56'h00_0000_0000_BEEF, 0, 24'h0, 1'b0};
        tbl[7] = '{3'b100, 56'h00_0000_0000_CAFE, 0, 24'h0, 1'b0};
        tbl[8] = '{3'b101, 56'h00_0000_0000_F00D, 0, 24'h0, 1'b0};

        // ---- reset state
        tick(); tick();
        check_rst_vals("reset");
        rst = 1'b0;
        tick();
        check_rst_vals("post reset");
        exp_spk = 0; exp_drop = 0;

        // ---- single SPIKE: credit in N+2, valid in N+3 for exactly one cycle
        spk_in_ready = 1'b1; config_in_ready = 1'b1;
        flit_in = mk(3'b000, 56'h00ABCD); flit_in_wr = 1'b1;
        tick(); flit_in_wr = 1'b0;                       // cycle N+1
        check("s1 credit N+1", 64'(credit_out), 64'(0));
        check("s1 valid N+1", 64'(spk_in_valid), 64'(0));
        tick();                                           // cycle N+2
        check("s1 credit N+2", 64'(credit_out), 64'(1));
        check("s1 valid N+2", 64'(spk_in_valid), 64'(0));
        tick();                                           // cycle N+3
        check("s1 valid N+3", 64'(spk_in_valid), 64'(1));
        check("s1 neuid", 64'(spk_in_neuid), 64'(24'h00ABCD));
        check("s1 cfg excl", 64'(config_in_valid), 64'(0));
        check("s1 credit N+3", 64'(credit_out), 64'(0));
        tick();
        check("s1 valid N+4", 64'(spk_in_valid), 64'(0));
        exp_spk++;
        tick();
        check("s1 spk_cnt", 64'(spk_in_spk_cnt), 64'(cexp(exp_spk)));

        // ---- WRITE, DATA, DATA_END, each held 5 cycles with ready low
        spk_in_ready = 1'b0; config_in_ready = 1'b0;
        c0 = credit_seen;
        cf[0] = mk(3'b110, 56'h00_0000_1000_0010);
        cf[1] = mk(3'b001, 56'h12_3456_789A_BCDE);
        cf[2] = mk(3'b010, 56'hFE_DCBA_9876_5432);
        for (int k = 0; k < 3; k++) send(cf[k]);
        for (int k = 0; k < 3; k++) begin
            wait_valid(1'b1, ok);
            check($sformatf("s2 wait %0d", k), 64'(ok), 64'(1));
            check($sformatf("s2 type %0d", k), 64'(config_in_type), 64'(cf[k][58:56]));
            check($sformatf("s2 data %0d", k), 64'(config_in_data), 64'(cf[k]));
            check($sformatf("s2 last %0d", k), 64'(config_in_last), 64'(k == 2));
            check($sformatf("s2 spk excl %0d", k), 64'(spk_in_valid), 64'(0));
            repeat (5) tick();
            check($sformatf("s2 hold %0d", k), 64'({config_in_valid, config_in_data}), 64'({1'b1, cf[k]}));
            config_in_ready = 1'b1;
            tick();
            config_in_ready = 1'b0;
            check($sformatf("s2 drop %0d", k), 64'(config_in_valid), 64'(0));
        end
        repeat (4) tick();
        check("s2 credits", 64'(credit_seen - c0), 64'(3));

        // ---- table of single flits, both readies high
        spk_in_ready = 1'b1; config_in_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            c0 = credit_seen;
            f = mk(tbl[i].t, tbl[i].pl);
            send(f);
            route = 0; got_id = '0; got_data = '0; got_last = 1'b0;
            for (int j = 0; j < 10; j++) begin
                if (route == 0 && spk_in_valid) begin
                    route = 1; got_id = spk_in_neuid;
                end else if (route == 0 && config_in_valid) begin
                    route = 2; got_data = config_in_data; got_last = config_in_last;
                end
                tick();
            end
            check($sformatf("tbl%0d route", i), 64'(route), 64'(tbl[i].route));
            if (tbl[i].route == 1) check($sformatf("tbl%0d neuid", i), 64'(got_id), 64'(tbl[i].neuid));
            if (tbl[i].route == 2) begin
                check($sformatf("tbl%0d data", i), 64'(got_data), 64'(f));
                check($sformatf("tbl%0d last", i), 64'(got_last), 64'(tbl[i].last));
            end
            check($sformatf("tbl%0d credit", i), 64'(credit_seen - c0), 64'(1));
            if (tbl[i].route == 0) exp_drop++;
            if (tbl[i].route == 1) exp_spk++;
        end
        check("tbl spk_cnt", 64'(spk_in_spk_cnt), 64'(cexp(exp_spk)));
        check("tbl drop_cnt", 64'(spk_in_drop_cnt), 64'(cexp(exp_drop)));
        check("tbl no overflow", 64'(spk_in_overflow), 64'(0));

        // ---- overflow: with readies low, the output register keeps the
        // first flit and the FIFO keeps 16 more, so the 18th is dropped.
        spk_in_ready = 1'b0; config_in_ready = 1'b0;
        c0 = credit_seen;
        for (int i = 0; i < 18; i++) begin
            flit_in = mk(3'b000, 56'(24'h100 + i)); flit_in_wr = 1'b1;
            tick();
        end
        flit_in_wr = 1'b0;
        tick();
        exp_drop++;
        check("ovf flag", 64'(spk_in_overflow), 64'(1));
        check("ovf drop_cnt", 64'(spk_in_drop_cnt), 64'(cexp(exp_drop)));
        spk_in_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            wait_valid(1'b0, ok);
            check($sformatf("ovf wait %0d", i), 64'(ok), 64'(1));
            check($sformatf("ovf order %0d", i), 64'(spk_in_neuid), 64'(24'h100 + i));
            tick();
        end
        repeat (6) tick();
        exp_spk += 17;
        check("ovf credits", 64'(credit_seen - c0), 64'(17));
        check("ovf empty", 64'(spk_in_valid), 64'(0));
        check("ovf spk_cnt", 64'(spk_in_spk_cnt), 64'(cexp(exp_spk)));
        check("ovf sticky", 64'(spk_in_overflow), 64'(1));

        // ---- random traffic: upstream sender limited by 15 credits
        q.delete(); ups = 15;
        prev_sv = 0; prev_sr = 0; prev_cv = 0; prev_cr = 0; prev_id = '0; prev_data = '0;
        for (int cyc = 0; cyc < 1600; cyc++) begin
            drain = (cyc >= 1500);
            ups += int'(credit_out);
            check("rnd excl", 64'(spk_in_valid & config_in_valid), 64'(0));
            if (prev_sv && !prev_sr)
                check("rnd spk hold", 64'({spk_in_valid, spk_in_neuid}), 64'({1'b1, prev_id}));
            if (prev_cv && !prev_cr)
                check("rnd cfg hold", 64'({config_in_valid, config_in_data}), 64'({1'b1, prev_data}));
            spk_in_ready    = drain || ($urandom_range(0, 2) != 0);
            config_in_ready = drain || ($urandom_range(0, 2) != 0);
            if (!drain && ups > 0 && $urandom_range(0, 1) == 1) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4: t = 3'b000;
                    5:             t = 3'b001;
                    6:             t = 3'b010;
                    7:             t = 3'b110;
                    8:             t = 3'b111;
                    default:       t = 3'(3 + $urandom_range(0, 2));
                endcase
                f = mk(t, {24'($urandom), 32'($urandom)});
                flit_in = f; flit_in_wr = 1'b1; ups--;
                if (known(t)) q.push_back(f); else exp_drop++;
                if (t == 3'b000) exp_spk++;
            end else begin
                flit_in_wr = 1'b0;
            end
            if (spk_in_valid && spk_in_ready) begin
                if (q.size() == 0) check("rnd spk unexpected", 64'(1), 64'(0));
                else begin
                    f = q.pop_front();
                    check("rnd spk route", 64'(f[58:56]), 64'(3'b000));
                    check("rnd spk id", 64'(spk_in_neuid), 64'(f[23:0]));
                end
            end
            if (config_in_valid && config_in_ready) begin
                if (q.size() == 0) check("rnd cfg unexpected", 64'(1), 64'(0));
                else begin
                    f = q.pop_front();
                    check("rnd cfg data", 64'(config_in_data), 64'(f));
                    check("rnd cfg last", 64'(config_in_last), 64'(f[58:56] == 3'b010));
                end
            end
            prev_sv = spk_in_valid; prev_sr = spk_in_ready; prev_id = spk_in_neuid;
            prev_cv = config_in_valid; prev_cr = config_in_ready; prev_data = config_in_data;
            tick();
        end
        flit_in_wr = 1'b0;
        check("rnd drained", 64'(q.size()), 64'(0));
        check("rnd credits back", 64'(ups), 64'(15));
        check("rnd spk_cnt", 64'(spk_in_spk_cnt), 64'(cexp(exp_spk)));
        check("rnd drop_cnt", 64'(spk_in_drop_cnt), 64'(cexp(exp_drop)));

        // ---- reset while presenting a spike with 3 more queued
        spk_in_ready = 1'b0; config_in_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(mk(3'b000, 56'(24'h300 + i)));
        wait_valid(1'b0, ok);
        check("rst wait spk", 64'(ok), 64'(1));
        #3 rst = 1'b1;
        #1 check_rst_vals("async rst");
        @(posedge clk_spk_in); #1;
        rst = 1'b0;
        spk_in_ready = 1'b1; config_in_ready = 1'b1;
        c0 = credit_seen; seen = 1'b0;
        repeat (12) begin
            if (spk_in_valid || config_in_valid || credit_out) seen = 1'b1;
            tick();
        end
        check("post rst quiet", 64'(seen), 64'(0));
        check("post rst credits", 64'(credit_seen - c0), 64'(0));
        send(mk(3'b000, 56'h777));
        wait_valid(1'b0, ok);
        check("post rst wait", 64'(ok), 64'(1));
        check("post rst neuid", 64'(spk_in_neuid), 64'(24'h777));
        tick(); tick();
        check("post rst spk_cnt", 64'(spk_in_spk_cnt), 64'(cexp(1)));
        check("post rst drop_cnt", 64'(spk_in_drop_cnt), 64'(cexp(0)));
        check("post rst overflow", 64'(spk_in_overflow), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
